// File: rtl/reg_rename_file_pkg.sv
// Shared configuration for the rename/architectural register file:
// RoB tag sizing and register-file geometry.
package reg_rename_file_pkg;

  localparam int ROB_SIZE_WIDTH = 3;
  localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;

endpackage : reg_rename_file_pkg

// File: rtl/reg_rename_file.sv
// Architectural register file with rename state: each register holds a
// committed value plus a busy flag and the RoB tag of its newest pending writer.
module reg_rename_file #(
  parameter int ROB_SIZE_WIDTH = reg_rename_file_pkg::ROB_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               val1,
  output logic [31:0]               val2,
  output logic                      busy1,
  output logic                      busy2,
  output logic [ROB_SIZE_WIDTH-1:0] dep1,
  output logic [ROB_SIZE_WIDTH-1:0] dep2
);

  localparam int REG_COUNT = reg_rename_file_pkg::REG_COUNT;

  logic [31:0]               value [REG_COUNT];
  logic                      busy  [REG_COUNT];
  logic [ROB_SIZE_WIDTH-1:0] tag   [REG_COUNT];

  logic commit_en;
  logic issue_en;
  logic commit_match;

  assign commit_en    = rdy && commit_valid && (commit_rd != 5'd0);
  assign issue_en     = rdy && issue_valid && (issue_rd != 5'd0) && !clear;
  assign commit_match = busy[commit_rd] && (tag[commit_rd] == commit_rob_id);

  // Issue is applied after commit so a same-cycle rename of the same rd wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value[i] <= '0;
        busy[i]  <= 1'b0;
        tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_en) begin
        value[commit_rd] <= commit_value;
      end
      if (clear) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          busy[i] <= 1'b0;
          tag[i]  <= '0;
        end
      end else begin
        if (commit_en && commit_match) begin
          busy[commit_rd] <= 1'b0;
        end
        if (issue_en) begin
          busy[issue_rd] <= 1'b1;
          tag[issue_rd]  <= issue_rob_id;
        end
      end
    end
  end

  // Reads see pre-issue state, with the retiring result forwarded.
  function automatic void read_port(
    input  logic [4:0]                rs,
    output logic [31:0]               v,
    output logic                      b,
    output logic [ROB_SIZE_WIDTH-1:0] d
  );
    v = '0;
    b = 1'b0;
    d = '0;
    if (rs != 5'd0) begin
      v = value[rs];
      b = busy[rs];
      d = busy[rs] ? tag[rs] : '0;
      if (rdy && commit_valid && (commit_rd == rs)) begin
        v = commit_value;
        if (tag[rs] == commit_rob_id) begin
          b = 1'b0;
          d = '0;
        end
      end
    end
  endfunction

  always_comb begin
    val1  = '0;
    busy1 = 1'b0;
    dep1  = '0;
    read_port(rs1, val1, busy1, dep1);
  end

  always_comb begin
    val2  = '0;
    busy2 = 1'b0;
    dep2  = '0;
    read_port(rs2, val2, busy2, dep2);
  end

endmodule : reg_rename_file

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: rename, commit forwarding, tag
// mismatch, issue/commit collisions, flush, x0, rdy stall and reset.
module tb_reg_rename_file;

  localparam int W = reg_rename_file_pkg::ROB_SIZE_WIDTH;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic          clear;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [W-1:0]  issue_rob_id;
  logic          commit_valid;
  logic [4:0]    commit_rd;
  logic [W-1:0]  commit_rob_id;
  logic [31:0]   commit_value;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [31:0]   val1;
  logic [31:0]   val2;
  logic          busy1;
  logic          busy2;
  logic [W-1:0]  dep1;
  logic [W-1:0]  dep2;

  int checks = 0;
  int errors = 0;

  reg_rename_file #(.ROB_SIZE_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .val1(val1), .val2(val2), .busy1(busy1), .busy2(busy2),
    .dep1(dep1), .dep2(dep2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
      end
  endtask

  // Checks all three port-1 outputs for the current rs1.
  task automatic check_port1(input string name, input logic [31:0] v,
                             input logic b, input logic [W-1:0] d);
    check_output({name, ".val1"},  val1,          v);
    check_output({name, ".busy1"}, {31'd0, busy1}, {31'd0, b});
    check_output({name, ".dep1"},  32'(dep1),     32'(d));
  endtask

  task automatic check_port2(input string name, input logic [31:0] v,
                             input logic b, input logic [W-1:0] d);
    check_output({name, ".val2"},  val2,          v);
    check_output({name, ".busy2"}, {31'd0, busy2}, {31'd0, b});
    check_output({name, ".dep2"},  32'(dep2),     32'(d));
  endtask

  task automatic apply_idle();
    clear        = 1'b0;
    issue_valid  = 1'b0;
    issue_rd     = 5'd0;
    issue_rob_id = '0;
    commit_valid = 1'b0;
    commit_rd    = 5'd0;
    commit_rob_id = '0;
    commit_value = '0;
  endtask

  task automatic apply_issue(input logic [4:0] rd, input logic [W-1:0] id);
    issue_valid  = 1'b1;
    issue_rd     = rd;
    issue_rob_id = id;
  endtask

  task automatic apply_commit(input logic [4:0] rd, input logic [W-1:0] id,
                              input logic [31:0] v);
    commit_valid  = 1'b1;
    commit_rd     = rd;
    commit_rob_id = id;
    commit_value  = v;
  endtask

  // Clock edge, then settle 1 time unit and return to idle inputs.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    apply_idle();
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rs1 = 5'd0;
    rs2 = 5'd0;
    apply_idle();
    apply_stimulus();
    apply_stimulus();
    rst = 1'b0;

    rs1 = 5'd5; rs2 = 5'd31; #1;
    check_port1("reset_x5", 32'h0, 1'b0, '0);
    check_port2("reset_x31", 32'h0, 1'b0, '0);

    // Rename x5 then retire it with forwarding
    apply_issue(5'd5, 3'd3);
    apply_stimulus();
    rs1 = 5'd5; #1;
    check_port1("issue_x5", 32'h0, 1'b1, 3'd3);
    apply_commit(5'd5, 3'd3, 32'hDEADBEEF); #1;
    check_port1("bypass_x5", 32'hDEADBEEF, 1'b0, '0);
    apply_stimulus();
    check_port1("stored_x5", 32'hDEADBEEF, 1'b0, '0);

    // Older writer retires while a younger one is pending
    apply_issue(5'd7, 3'd1);
    apply_stimulus();
    apply_issue(5'd7, 3'd2);
    apply_stimulus();
    rs2 = 5'd7;
    apply_commit(5'd7, 3'd1, 32'h11); #1;
    check_port2("bypass_mismatch_x7", 32'h11, 1'b1, 3'd2);
    apply_stimulus();
    check_port2("stored_mismatch_x7", 32'h11, 1'b1, 3'd2);

    // Same-cycle commit and issue to x9
    apply_commit(5'd9, 3'd4, 32'h22);
    apply_issue(5'd9, 3'd5);
    apply_stimulus();
    rs1 = 5'd9; #1;
    check_port1("collide_x9", 32'h22, 1'b1, 3'd5);

    // Flush with commit and issue in the same cycle
    for (int i = 1; i <= 4; i++) begin
      apply_issue(5'(i), W'(i - 1));
      apply_stimulus();
    end
    rs1 = 5'd4; #1;
    check_port1("pre_clear_x4", 32'h0, 1'b1, 3'd3);
    clear = 1'b1;
    apply_commit(5'd8, 3'd0, 32'h33);
    apply_issue(5'd6, 3'd6);
    apply_stimulus();
    for (int i = 1; i <= 4; i++) begin
      rs1 = 5'(i); #1;
      check_port1($sformatf("clear_x%0d", i), 32'h0, 1'b0, '0);
    end
    rs1 = 5'd8; rs2 = 5'd6; #1;
    check_port1("clear_commit_x8", 32'h33, 1'b0, '0);
    check_port2("clear_issue_x6", 32'h0, 1'b0, '0);
    rs1 = 5'd7; rs2 = 5'd9; #1;
    check_port1("clear_x7", 32'h11, 1'b0, '0);
    check_port2("clear_x9", 32'h22, 1'b0, '0);

    // x0 is hard-wired
    rs1 = 5'd0;
    apply_issue(5'd0, 3'd2);
    apply_commit(5'd0, 3'd2, 32'hFFFFFFFF); #1;
    check_port1("x0_bypass", 32'h0, 1'b0, '0);
    apply_stimulus();
    check_port1("x0_after", 32'h0, 1'b0, '0);

    // rdy low freezes everything, including flush
    apply_issue(5'd10, 3'd4);
    apply_stimulus();
    rdy = 1'b0;
    rs1 = 5'd3; rs2 = 5'd10;
    apply_issue(5'd3, 3'd7);
    apply_commit(5'd3, 3'd0, 32'h55);
    clear = 1'b1; #1;
    check_port1("stall_bypass_x3", 32'h0, 1'b0, '0);
    apply_stimulus();
    rdy = 1'b1; #1;
    check_port1("stall_x3", 32'h0, 1'b0, '0);
    check_port2("stall_x10", 32'h0, 1'b1, 3'd4);

    // Reset in the middle of activity
    apply_commit(5'd5, 3'd0, 32'h44);
    apply_stimulus();
    apply_issue(5'd5, 3'd2);
    apply_stimulus();
    rs1 = 5'd5; #1;
    check_port1("pre_reset_x5", 32'h44, 1'b1, 3'd2);
    rst = 1'b1;
    apply_commit(5'd12, 3'd0, 32'h99);
    apply_issue(5'd13, 3'd1);
    apply_stimulus();
    rst = 1'b0;
    rs1 = 5'd5; rs2 = 5'd12; #1;
    check_port1("post_reset_x5", 32'h0, 1'b0, '0);
    check_port2("post_reset_x12", 32'h0, 1'b0, '0);
    rs1 = 5'd8; rs2 = 5'd13; #1;
    check_port1("post_reset_x8", 32'h0, 1'b0, '0);
    check_port2("post_reset_x13", 32'h0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_rename_file

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 The parameter list SHALL be: ROB_SIZE_WIDTH, default taken from the shared config package (3), width of a RoB entry tag.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rdy  in  1  global enable; low freezes all state.
REQ-005 clear  in  1  misprediction flush from RoB.
REQ-006 issue_valid  in  1  decoder issues an instruction that writes rd.
REQ-007 issue_rd  in  5  destination register of issued instruction.
REQ-008 issue_rob_id  in  ROB_SIZE_WIDTH  RoB tail entry allocated to it.
REQ-009 commit_valid  in  1  RoB head retires a register-writing instruction.
REQ-010 commit_rd  in  5  destination of retiring instruction.
REQ-011 commit_rob_id  in  ROB_SIZE_WIDTH  RoB entry retiring.
REQ-012 commit_value  in  32  result to write.
REQ-013 rs1, rs2  in  5 each  source register read addresses.
REQ-014 val1, val2  out  32 each  architectural value of rs1/rs2.
REQ-015 busy1, busy2  out  1 each  source still awaits an in-flight producer.
REQ-016 dep1, dep2  out  ROB_SIZE_WIDTH each  RoB tag of that producer; 0 when not busy.

Function
REQ-017 State: 32 x 32-bit values, 32 busy bits, 32 tags; x0 SHALL read 0, never busy, and ignore all writes.
REQ-018 Commit (rdy, commit_valid, commit_rd!=0): value[commit_rd] <= commit_value next edge, regardless of tag.
REQ-019 Commit SHALL clear busy[commit_rd] only if busy and tag[commit_rd]==commit_rob_id; a mismatched tag (a younger writer pending) leaves busy/tag unchanged.
REQ-020 Issue (rdy, issue_valid, issue_rd!=0, !clear): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
REQ-021 Same-cycle issue and commit to the same rd: value written, issue wins: busy stays 1, tag = issue_rob_id.
REQ-022 clear && rdy: all busy bits and tags SHALL be zeroed next edge; a same-cycle commit still writes its value; same-cycle issue is dropped.
REQ-023 rdy low: no value, busy or tag change, whatever the other inputs.
REQ-024 Read ports combinational, zero latency; read of rsN reflects state before any same-cycle issue (an instruction never sees its own rename).
REQ-025 Commit bypass: when rdy, commit_valid, commit_rd==rsN, rsN!=0: valN = commit_value; busyN = 0 and depN = 0 if the commit tag matches tag[rsN], else busyN/depN from stored state.
REQ-026 Otherwise valN = value[rsN], busyN = busy[rsN], depN = busy ? tag[rsN] : 0; rsN==0 gives val 0, busy 0, dep 0.
REQ-027 Tag wrap-around is the RoB's concern; tags are compared for equality only, at full ROB_SIZE_WIDTH.

Reset
REQ-028 On rst: all values, busy bits and tags SHALL be 0; outputs val/busy/dep read 0 for every address in the cycle after reset.
REQ-029 rst SHALL take priority over rdy, clear, issue and commit.

Structure
REQ-030 ROB_SIZE_WIDTH, ROB_SIZE and the register-count constant SHALL live in the shared config package, not in this module.
REQ-031 Single flat module; no sub-module is natural.

Verification
REQ-032 Issue x5 tag 3; next cycle rs1=5 -> busy1=1, dep1=3; commit x5 tag 3 value 0xDEADBEEF -> same cycle val1=0xDEADBEEF, busy1=0; next cycle stored.
REQ-033 Issue x7 tag 1, then x7 tag 2; commit x7 tag 1 value 0x11 -> value 0x11, busy stays 1, dep=2.
REQ-034 Same cycle: commit x9 tag 4 value 0x22 and issue x9 tag 5 -> next cycle val=0x22, busy=1, dep=5.
REQ-035 Issue x1..x4 tags 0..3, then clear with commit x8 value 0x33 and issue x6 -> all busy=0, x8=0x33, x6 not busy.
REQ-036 Issue/commit to x0 with value 0xFFFFFFFF -> x0 reads 0, busy 0; rdy=0 with issue x3 -> x3 unchanged.
REQ-037 Reset mid-operation with x5 busy and value 0x44 -> next cycle all values 0, all busy 0.
